// File: rtl/vd_host_core.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// vd_host_core
//
// Single-clock video DMA loopback host. Pixel words arriving on the AXI4-Stream
// slave are written into a two-frame (ping-pong) buffer. Only whole frames are
// replayed, in arrival order, on the AXI4-Stream master.
//
// Parameters
//   FRAME_WORDS : words per frame (power of two, >= 4)
//   DATA_W      : stream data width
//
// Ports
//   aclk_0           in   sole clock, rising edge
//   aresetn_0        in   synchronous active-low reset
//   s_axis_0_tdata   in   input pixel word
//   s_axis_0_tvalid  in   input word valid
//   s_axis_0_tready  out  block can accept a word (registered)
//   m_axis_0_tdata   out  output pixel word (registered)
//   m_axis_0_tvalid  out  output word valid (registered)
//   m_axis_0_tready  in   downstream accepts
//
// Structure
//   Writer : wr_buf_r / wr_addr_r walk a buffer; the last word of a frame sets
//            full_r[wr_buf_r] and flips to the other buffer.
//   Issuer : iss_buf_r / iss_addr_r issue synchronous RAM reads of full
//            buffers. It may run ahead into the next buffer before the current
//            frame has fully left, which keeps back-to-back frames bubble-free.
//   Skid   : a 2-entry output FIFO plus one read in flight. Reads are issued
//            only when the FIFO is guaranteed to have room for the result.
//   Release: each FIFO entry carries a "last word of frame" tag; when a tagged
//            entry is accepted downstream, full_r[rd_buf_r] clears and
//            rd_buf_r flips.
// -----------------------------------------------------------------------------
module vd_host_core #(
    parameter int FRAME_WORDS = 256,
    parameter int DATA_W      = 32
) (
    input  logic              aclk_0,
    input  logic              aresetn_0,
    input  logic [DATA_W-1:0] s_axis_0_tdata,
    input  logic              s_axis_0_tvalid,
    output logic              s_axis_0_tready,
    output logic [DATA_W-1:0] m_axis_0_tdata,
    output logic              m_axis_0_tvalid,
    input  logic              m_axis_0_tready
);

    localparam int            AW        = $clog2(FRAME_WORDS);
    localparam int            MW        = AW + 1;
    localparam int            MEM_WORDS = 2 * FRAME_WORDS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    // ---------------------------------------------------------------- state
    logic [DATA_W-1:0] mem_r [0:MEM_WORDS-1];

    logic [1:0]        full_r;
    logic              wr_buf_r;
    logic [AW-1:0]     wr_addr_r;
    logic              s_ready_r;

    logic              iss_buf_r;
    logic [AW-1:0]     iss_addr_r;
    logic              pend_r;
    logic              pend_last_r;
    logic [DATA_W-1:0] rdata_r;
    logic              rd_buf_r;

    logic [1:0]        cnt_r;
    logic [DATA_W-1:0] d0_r;
    logic [DATA_W-1:0] d1_r;
    logic              l0_r;
    logic              l1_r;
    logic              m_valid_r;

    // ------------------------------------------------------------ combinational
    logic              wr_beat_s;
    logic              wr_last_s;
    logic              pop_s;
    logic              release_s;
    logic [1:0]        occ_s;
    logic              issue_s;
    logic              iss_last_s;
    logic [1:0]        full_set_s;
    logic [1:0]        full_clr_s;
    logic [1:0]        full_nxt_s;
    logic              wr_buf_nxt_s;
    logic [MW-1:0]     wr_mem_addr_s;
    logic [MW-1:0]     rd_mem_addr_s;

    logic [1:0]        cnt_nxt_s;
    logic [DATA_W-1:0] d0_nxt_s;
    logic [DATA_W-1:0] d1_nxt_s;
    logic              l0_nxt_s;
    logic              l1_nxt_s;

    assign s_axis_0_tready = s_ready_r;
    assign m_axis_0_tdata  = d0_r;
    assign m_axis_0_tvalid = m_valid_r;

    assign wr_beat_s     = s_axis_0_tvalid & s_ready_r;
    assign wr_last_s     = wr_beat_s & (wr_addr_r == LAST_ADDR);
    assign pop_s         = m_valid_r & m_axis_0_tready;
    assign release_s     = pop_s & l0_r;
    assign wr_buf_nxt_s  = wr_buf_r ^ wr_last_s;
    assign wr_mem_addr_s = {wr_buf_r, wr_addr_r};
    assign rd_mem_addr_s = {iss_buf_r, iss_addr_r};

    // Occupancy counts the FIFO plus the read already in flight; a new read is
    // safe only if that total, after this cycle's pop, stays within 2 entries.
    assign occ_s      = cnt_r + {1'b0, pend_r};
    assign issue_s    = full_r[iss_buf_r] &
                        ((occ_s < 2'd2) | ((occ_s == 2'd2) & pop_s));
    assign iss_last_s = issue_s & (iss_addr_r == LAST_ADDR);

    // Full-flag set/clear masks; the writer never targets a full buffer, so a
    // set and a clear never hit the same bit in one cycle.
    always_comb begin
        full_set_s = 2'b00;
        full_clr_s = 2'b00;
        if (wr_last_s) begin
            full_set_s[wr_buf_r] = 1'b1;
        end else begin
            full_set_s = 2'b00;
        end
        if (release_s) begin
            full_clr_s[rd_buf_r] = 1'b1;
        end else begin
            full_clr_s = 2'b00;
        end
        full_nxt_s = (full_r | full_set_s) & ~full_clr_s;
    end

    // Writer pointers, full flags and the registered slave ready.
    always_ff @(posedge aclk_0) begin
        if (!aresetn_0) begin
            full_r    <= 2'b00;
            wr_buf_r  <= 1'b0;
            wr_addr_r <= '0;
            s_ready_r <= 1'b0;
        end else begin
            if (wr_beat_s) begin
                wr_addr_r <= wr_addr_r + ADDR_ONE;
            end
            full_r    <= full_nxt_s;
            wr_buf_r  <= wr_buf_nxt_s;
            // Ready for next cycle is derived from next-state only, never from
            // s_axis_0_tvalid of the current cycle.
            s_ready_r <= ~full_nxt_s[wr_buf_nxt_s];
        end
    end

    // Frame memory write port.
    always_ff @(posedge aclk_0) begin
        if (wr_beat_s) begin
            mem_r[wr_mem_addr_s] <= s_axis_0_tdata;
        end
    end

    // Frame memory synchronous read port.
    always_ff @(posedge aclk_0) begin
        if (issue_s) begin
            rdata_r <= mem_r[rd_mem_addr_s];
        end
    end

    // Read issue pointers, in-flight tracking and the release pointer.
    always_ff @(posedge aclk_0) begin
        if (!aresetn_0) begin
            iss_buf_r   <= 1'b0;
            iss_addr_r  <= '0;
            pend_r      <= 1'b0;
            pend_last_r <= 1'b0;
            rd_buf_r    <= 1'b0;
        end else begin
            if (issue_s) begin
                iss_addr_r <= iss_addr_r + ADDR_ONE;
            end
            iss_buf_r   <= iss_buf_r ^ iss_last_s;
            pend_r      <= issue_s;
            pend_last_r <= iss_last_s;
            if (release_s) begin
                rd_buf_r <= ~rd_buf_r;
            end
        end
    end

    // Output FIFO next state: entry 0 is always the word presented downstream.
    always_comb begin
        cnt_nxt_s = cnt_r;
        d0_nxt_s  = d0_r;
        d1_nxt_s  = d1_r;
        l0_nxt_s  = l0_r;
        l1_nxt_s  = l1_r;
        case ({pop_s, pend_r})
            2'b10: begin
                d0_nxt_s  = d1_r;
                l0_nxt_s  = l1_r;
                l1_nxt_s  = 1'b0;
                cnt_nxt_s = cnt_r - 2'd1;
            end
            2'b01: begin
                if (cnt_r == 2'd0) begin
                    d0_nxt_s = rdata_r;
                    l0_nxt_s = pend_last_r;
                end else begin
                    d1_nxt_s = rdata_r;
                    l1_nxt_s = pend_last_r;
                end
                cnt_nxt_s = cnt_r + 2'd1;
            end
            2'b11: begin
                if (cnt_r == 2'd1) begin
                    d0_nxt_s = rdata_r;
                    l0_nxt_s = pend_last_r;
                end else begin
                    d0_nxt_s = d1_r;
                    l0_nxt_s = l1_r;
                    d1_nxt_s = rdata_r;
                    l1_nxt_s = pend_last_r;
                end
            end
            default: begin
                cnt_nxt_s = cnt_r;
            end
        endcase
    end

    // Output FIFO registers and the registered master valid.
    always_ff @(posedge aclk_0) begin
        if (!aresetn_0) begin
            cnt_r     <= 2'd0;
            d0_r      <= '0;
            d1_r      <= '0;
            l0_r      <= 1'b0;
            l1_r      <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_nxt_s;
            d0_r      <= d0_nxt_s;
            d1_r      <= d1_nxt_s;
            l0_r      <= l0_nxt_s;
            l1_r      <= l1_nxt_s;
            m_valid_r <= (cnt_nxt_s != 2'd0);
        end
    end

endmodule

// File: tb/tb_vd_host_core.sv
`timescale 1ns/1ps
// Self-checking bench for vd_host_core: directed phases with a scoreboard
// queue filled on accepted input beats and drained on accepted output beats.
module tb_vd_host_core;

    logic        aclk_0 = 1'b0;
    logic        aresetn_0;
    logic [31:0] s_axis_0_tdata;
    logic        s_axis_0_tvalid;
    logic        s_axis_0_tready;
    logic [31:0] m_axis_0_tdata;
    logic        m_axis_0_tvalid;
    logic        m_axis_0_tready;

    always #5 aclk_0 = ~aclk_0;

    vd_host_core #(.FRAME_WORDS(256), .DATA_W(32)) dut (
        .aclk_0          (aclk_0),
        .aresetn_0       (aresetn_0),
        .s_axis_0_tdata  (s_axis_0_tdata),
        .s_axis_0_tvalid (s_axis_0_tvalid),
        .s_axis_0_tready (s_axis_0_tready),
        .m_axis_0_tdata  (m_axis_0_tdata),
        .m_axis_0_tvalid (m_axis_0_tvalid),
        .m_axis_0_tready (m_axis_0_tready)
    );

    int          checks;
    int          errors;
    int unsigned in_cnt;
    int unsigned out_cnt;
    logic [31:0] exp_q[$];
    logic        stall_v;
    logic [31:0] stall_d;

    int unsigned in_base;
    int unsigned out_base;
    int unsigned src_base;
    int          g;
    int          extra;
    int          t_in;
    int          t_out;
    int          gaps;
    int unsigned prev_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk_0);
        #1;
    endtask

    task automatic tick_src();
        tick();
        s_axis_0_tdata = src_base + (in_cnt - in_base);
    endtask

    initial begin
        checks = 0; errors = 0; in_cnt = 0; out_cnt = 0;
        stall_v = 1'b0; stall_d = 32'd0;
        in_base = 0; out_base = 0; src_base = 0;
        aresetn_0 = 1'b0;
        s_axis_0_tvalid = 1'b1;
        s_axis_0_tdata = 32'hA5A5_0000;
        m_axis_0_tready = 1'b1;

        // Monitor / scoreboard: evaluated mid-cycle, describes the next edge.
        fork
            forever begin
                @(negedge aclk_0);
                if (!aresetn_0) begin
                    exp_q.delete();
                    stall_v = 1'b0;
                end else begin
                    if (stall_v) begin
                        check("m_hold_valid", 32'(m_axis_0_tvalid), 32'd1);
                        check("m_hold_data", m_axis_0_tdata, stall_d);
                    end
                    if (s_axis_0_tvalid && s_axis_0_tready) begin
                        exp_q.push_back(s_axis_0_tdata);
                        in_cnt++;
                    end
                    if (m_axis_0_tvalid && m_axis_0_tready) begin
                        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            check("out_data", m_axis_0_tdata, exp_q.pop_front());
                        end
                        out_cnt++;
                    end
                    stall_v = m_axis_0_tvalid && !m_axis_0_tready;
                    stall_d = m_axis_0_tdata;
                end
            end
        join_none

        // ---- reset held 5 cycles with both valid/ready driven
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_s_tready", 32'(s_axis_0_tready), 32'd0);
            check("rst_m_tvalid", 32'(m_axis_0_tvalid), 32'd0);
        end
        check("rst_m_tdata", m_axis_0_tdata, 32'd0);
        aresetn_0 = 1'b1;
        s_axis_0_tvalid = 1'b0;
        m_axis_0_tready = 1'b0;
        tick();
        check("post_rst_s_tready", 32'(s_axis_0_tready), 32'd1);
        check("post_rst_m_tvalid", 32'(m_axis_0_tvalid), 32'd0);

        // ---- fill and stall
        while ($time < 1000) tick();
        in_base = in_cnt; src_base = 0;
        s_axis_0_tdata = 32'd0;
        s_axis_0_tvalid = 1'b1;
        extra = 0;
        for (int i = 0; i < 600; i++) begin
            tick_src();
            if ((in_cnt - in_base) >= 512 && s_axis_0_tready) extra++;
        end
        check("fill_accepted", in_cnt - in_base, 32'd512);
        check("fill_ready_rose", 32'(extra), 32'd0);
        check("fill_s_tready", 32'(s_axis_0_tready), 32'd0);
        check("fill_m_tvalid", 32'(m_axis_0_tvalid), 32'd1);
        check("fill_m_tdata", m_axis_0_tdata, 32'd0);

        // ---- drain
        m_axis_0_tready = 1'b1;
        out_base = out_cnt;
        g = 0;
        while ((out_cnt - out_base) < 255 && g < 300) begin
            tick_src();
            g++;
        end
        check("drain_cycles_255", 32'(g), 32'd255);
        check("drain_s_tready_held", 32'(s_axis_0_tready), 32'd0);
        tick_src();
        g++;
        check("drain_s_tready_rise", 32'(s_axis_0_tready), 32'd1);
        check("drain_no_input_during_stall", in_cnt - in_base, 32'd512);
        while ((out_cnt - out_base) < 512 && g < 700) begin
            tick_src();
            g++;
        end
        check("drain_cycles_512", 32'(g), 32'd512);
        g = 0;
        while (((in_cnt - in_base) % 256) != 0 && g < 600) begin
            tick_src();
            g++;
        end
        s_axis_0_tvalid = 1'b0;
        g = 0;
        while ((exp_q.size() != 0 || m_axis_0_tvalid) && g < 2000) begin
            tick();
            g++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // ---- streaming, both sides always ready
        in_base = in_cnt; out_base = out_cnt; src_base = 0;
        s_axis_0_tdata = 32'd0;
        s_axis_0_tvalid = 1'b1;
        t_in = -1; t_out = -1; gaps = 0; prev_out = 0;
        for (int k = 0; k < 4000 && (out_cnt - out_base) < 2048; k++) begin
            tick();
            if ((in_cnt - in_base) >= 2048) s_axis_0_tvalid = 1'b0;
            else s_axis_0_tdata = src_base + (in_cnt - in_base);
            if (t_in < 0 && (in_cnt - in_base) >= 1) t_in = k;
            if (t_out < 0 && (out_cnt - out_base) >= 1) t_out = k;
            if (t_out >= 0 && (out_cnt - out_base) == prev_out &&
                prev_out < 2048 && (prev_out % 256) != 0) gaps++;
            prev_out = out_cnt - out_base;
        end
        check("stream_count", out_cnt - out_base, 32'd2048);
        check("stream_latency_le_258", 32'((t_out - t_in) <= 258 && t_in >= 0), 32'd1);
        check("stream_intraframe_gaps", 32'(gaps), 32'd0);
        check("stream_empty", 32'(exp_q.size()), 32'd0);

        // ---- random backpressure
        in_base = in_cnt; out_base = out_cnt; src_base = 32'h5000;
        s_axis_0_tdata = src_base;
        g = 0;
        while ((out_cnt - out_base) < 1024 && g < 8000) begin
            s_axis_0_tvalid = ((in_cnt - in_base) < 1024) && ($urandom_range(0, 3) != 0);
            m_axis_0_tready = ($urandom_range(0, 9) < 6);
            tick_src();
            g++;
        end
        s_axis_0_tvalid = 1'b0;
        m_axis_0_tready = 1'b1;
        check("rand_in_count", in_cnt - in_base, 32'd1024);
        check("rand_out_count", out_cnt - out_base, 32'd1024);
        check("rand_empty", 32'(exp_q.size()), 32'd0);

        // ---- mid-frame reset
        tick();
        in_base = in_cnt; src_base = 32'd7000;
        s_axis_0_tdata = src_base;
        s_axis_0_tvalid = 1'b1;
        g = 0;
        while ((in_cnt - in_base) < 100 && g < 300) begin
            tick_src();
            g++;
        end
        s_axis_0_tvalid = 1'b0;
        check("pre_rst_accepted", in_cnt - in_base, 32'd100);
        aresetn_0 = 1'b0;
        tick();
        tick();
        aresetn_0 = 1'b1;
        tick();
        check("mid_rst_s_tready", 32'(s_axis_0_tready), 32'd1);
        check("mid_rst_m_tvalid", 32'(m_axis_0_tvalid), 32'd0);
        in_base = in_cnt; out_base = out_cnt; src_base = 32'd1000;
        s_axis_0_tdata = src_base;
        s_axis_0_tvalid = 1'b1;
        g = 0;
        while ((out_cnt - out_base) < 256 && g < 700) begin
            tick_src();
            if ((in_cnt - in_base) >= 256) s_axis_0_tvalid = 1'b0;
            g++;
        end
        s_axis_0_tvalid = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("mid_rst_out_count", out_cnt - out_base, 32'd256);
        check("mid_rst_empty", 32'(exp_q.size()), 32'd0);
        check("mid_rst_idle_valid", 32'(m_axis_0_tvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
